// File: rtl/cpu_pkg.sv
// Shared types and constants for the writeback slice.
// Register 0 is hardwired zero.
package cpu_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 32;
  localparam int REG_BITS   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_MEM
  } wb_state_t;

  typedef struct packed {
    logic [REG_BITS-1:0]   reg_dest;
    logic                  write_back;
    logic                  is_load;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cpu_writeback_stage_if.sv
// Commit -> writeback handshake bundle.
// The master is the commit stage, the slave is WB.
interface cpu_writeback_stage_if;
  import cpu_pkg::*;

  logic                  commit_valid;
  logic                  commit_ready;
  logic [REG_BITS-1:0]   commit_reg_dest;
  logic                  commit_write_back;
  logic                  commit_is_load;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  flush;

  modport master (
    output commit_valid,
    output commit_reg_dest,
    output commit_write_back,
    output commit_is_load,
    output commit_data,
    output flush,
    input  commit_ready
  );

  modport slave (
    input  commit_valid,
    input  commit_reg_dest,
    input  commit_write_back,
    input  commit_is_load,
    input  commit_data,
    input  flush,
    output commit_ready
  );

endinterface

// File: rtl/cpu_writeback_stage.sv
// Writeback stage: holds one committed instruction,
// drives the RF write port and forwarding sources.
module cpu_writeback_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  cpu_writeback_stage_if.slave  cmt,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  rf_we,
  output logic [REG_BITS-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [REG_BITS-1:0]   reg_dest_commit,
  output logic                  write_back_commit,
  output logic [DATA_WIDTH-1:0] commit_fw_data,
  output logic [REG_BITS-1:0]   reg_dest_wb,
  output logic                  write_back_wb,
  output logic [DATA_WIDTH-1:0] wb_fw_data,
  output logic                  load_pending,
  output logic [31:0]           retired_count,
  output logic                  err_spurious_resp
);

  wb_state_t state_q, state_d;
  wb_entry_t entry_q, entry_d;
  wb_entry_t new_entry;

  logic held;
  logic complete;
  logic accept;
  logic waiting;

  assign waiting = (state_q == S_WAIT_MEM);
  assign held    = (state_q != S_IDLE);

  // Reset overrides completion so a pending load is dropped unwritten
  assign complete = !reset &
    ((state_q == S_HOLD) | (waiting & mem_resp_valid));

  assign cmt.commit_ready = !reset & (!waiting | mem_resp_valid);
  assign accept = cmt.commit_valid & cmt.commit_ready & !cmt.flush;

  assign new_entry.reg_dest   = cmt.commit_reg_dest;
  assign new_entry.write_back = cmt.commit_write_back;
  assign new_entry.is_load    = cmt.commit_is_load;
  assign new_entry.data       = cmt.commit_data;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (!held || complete) begin
      if (accept) begin
        state_d = new_entry.is_load ? S_WAIT_MEM : S_HOLD;
        entry_d = new_entry;
      end else begin
        state_d = S_IDLE;
        entry_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      entry_q           <= '0;
      retired_count     <= '0;
      err_spurious_resp <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      if (complete)
        retired_count <= retired_count + 32'd1;
      if (mem_resp_valid && !waiting)
        err_spurious_resp <= 1'b1;
    end
  end

  assign rf_we = complete & entry_q.write_back &
                 (entry_q.reg_dest != '0);
  assign rf_waddr = held ? entry_q.reg_dest : '0;
  assign rf_wdata = entry_q.is_load ? mem_resp_data
                                    : entry_q.data;

  assign write_back_wb = rf_we;
  assign reg_dest_wb   = held ? entry_q.reg_dest : '0;
  assign wb_fw_data    = rf_wdata;
  assign load_pending  = waiting;

  // Loads have no data yet at commit, so they never forward from here
  assign write_back_commit = cmt.commit_valid &
    cmt.commit_write_back & !cmt.commit_is_load &
    !cmt.flush & (cmt.commit_reg_dest != '0);
  assign reg_dest_commit = cmt.commit_reg_dest;
  assign commit_fw_data  = cmt.commit_data;

endmodule

// File: tb/tb_cpu_writeback_stage.sv
// Directed vector bench for cpu_writeback_stage.
// Inputs change on negedge, outputs sampled #1 later.
module tb_cpu_writeback_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0] reg_dest_commit;
  logic write_back_commit;
  logic [31:0] commit_fw_data;
  logic [4:0] reg_dest_wb;
  logic write_back_wb;
  logic [31:0] wb_fw_data;
  logic load_pending;
  logic [31:0] retired_count;
  logic err_spurious_resp;

  int total = 0;
  int bad   = 0;

  cpu_writeback_stage_if cif();

  cpu_writeback_stage dut (
    .clk               (clk),
    .reset             (reset),
    .cmt               (cif.slave),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .reg_dest_commit   (reg_dest_commit),
    .write_back_commit (write_back_commit),
    .commit_fw_data    (commit_fw_data),
    .reg_dest_wb       (reg_dest_wb),
    .write_back_wb     (write_back_wb),
    .wb_fw_data        (wb_fw_data),
    .load_pending      (load_pending),
    .retired_count     (retired_count),
    .err_spurious_resp (err_spurious_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        wb;
    logic        ld;
    logic [31:0] d;
    logic        fl;
    logic        mv;
    logic [31:0] md;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_wbc;
    logic        e_lp;
    logic [4:0]  e_rdwb;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rd, logic wb,
                       logic ld, logic [31:0] d, logic fl,
                       logic mv, logic [31:0] md);
    cif.commit_valid      = v;
    cif.commit_reg_dest   = rd;
    cif.commit_write_back = wb;
    cif.commit_is_load    = ld;
    cif.commit_data       = d;
    cif.flush             = fl;
    mem_resp_valid        = mv;
    mem_resp_data         = md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{1,5,1,0,'h11,0,0,0, 1,0,0,0,1,0,0,0};
    tbl[1]  = '{1,6,1,0,'h22,0,0,0, 1,1,5,'h11,1,0,5,0};
    tbl[2]  = '{1,7,1,0,'h33,0,0,0, 1,1,6,'h22,1,0,6,1};
    tbl[3]  = '{0,0,0,0,0,0,0,0, 1,1,7,'h33,0,0,7,2};
    tbl[4]  = '{0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,3};
    tbl[5]  = '{1,9,1,1,'h1234,0,0,0, 1,0,0,0,0,0,0,3};
    tbl[6]  = '{1,10,1,0,'h77,0,0,0, 0,0,0,0,1,1,9,3};
    tbl[7]  = '{1,10,1,0,'h77,0,0,0, 0,0,0,0,1,1,9,3};
    tbl[8]  = '{1,10,1,0,'h77,0,0,0, 0,0,0,0,1,1,9,3};
    tbl[9]  = '{1,10,1,0,'h77,0,1,'hDEADBEEF,
                1,1,9,'hDEADBEEF,1,1,9,3};
    tbl[10] = '{0,0,0,0,0,0,0,0, 1,1,10,'h77,0,0,10,4};
    tbl[11] = '{1,0,1,0,'h55,0,0,0, 1,0,0,0,0,0,0,5};
    tbl[12] = '{0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,5};
    tbl[13] = '{1,3,1,0,'h99,1,0,0, 1,0,0,0,0,0,0,6};
    tbl[14] = '{0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,6};
    tbl[15] = '{1,4,1,0,'h44,0,0,0, 1,0,0,0,1,0,0,6};
    tbl[16] = '{1,3,1,0,'h99,1,0,0, 1,1,4,'h44,0,0,4,6};
    tbl[17] = '{0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,7};
    tbl[18] = '{1,8,0,1,0,0,0,0, 1,0,0,0,0,0,0,7};
    tbl[19] = '{0,0,0,0,0,0,1,'hAA, 1,0,0,0,0,1,8,7};
    tbl[20] = '{0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,8};

    // Reset with a forwardable commit input present
    reset = 1'b1;
    drive(1, 5, 1, 0, 'h5A5A, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", cif.commit_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_rdwb", reg_dest_wb, 0);
    chk("rst_lp", load_pending, 0);
    chk("rst_cnt", retired_count, 0);
    chk("rst_err", err_spurious_resp, 0);
    chk("rst_wbc", write_back_commit, 1);
    chk("rst_rdc", reg_dest_commit, 5);
    chk("rst_fwd", commit_fw_data, 'h5A5A);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].wb, tbl[i].ld,
            tbl[i].d, tbl[i].fl, tbl[i].mv, tbl[i].md);
      #1;
      chk($sformatf("v%0d_ready", i),
          cif.commit_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("v%0d_wbwb", i),
          write_back_wb, tbl[i].e_we);
      chk($sformatf("v%0d_wbc", i),
          write_back_commit, tbl[i].e_wbc);
      chk($sformatf("v%0d_rdc", i),
          reg_dest_commit, tbl[i].rd);
      chk($sformatf("v%0d_fwd", i),
          commit_fw_data, tbl[i].d);
      chk($sformatf("v%0d_lp", i),
          load_pending, tbl[i].e_lp);
      chk($sformatf("v%0d_rdwb", i),
          reg_dest_wb, tbl[i].e_rdwb);
      chk($sformatf("v%0d_cnt", i),
          retired_count, tbl[i].e_cnt);
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_wa", i), rf_waddr, tbl[i].e_wa);
        chk($sformatf("v%0d_wd", i), rf_wdata, tbl[i].e_wd);
        chk($sformatf("v%0d_wbd", i),
            wb_fw_data, tbl[i].e_wd);
      end
      @(negedge clk);
    end
    chk("err_clean", err_spurious_resp, 0);

    // Reset while a load waits, then a late response
    drive(1, 12, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    #1;
    chk("ml_lp", load_pending, 1);
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 'h1111;
    #1;
    chk("ml_rst_we", rf_we, 0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    chk("ml_lp0", load_pending, 0);
    chk("ml_cnt0", retired_count, 0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 'h5555;
    #1;
    chk("ml_late_we", rf_we, 0);
    @(negedge clk);
    idle();
    #1;
    chk("ml_err", err_spurious_resp, 1);
    chk("ml_cnt", retired_count, 0);

    // Counter wrap via a preloaded count
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    @(negedge clk);
    drive(1, 1, 1, 0, 'h1, 0, 0, 0);
    @(negedge clk);
    idle();
    #1;
    chk("wrap_we", rf_we, 1);
    @(negedge clk);
    #1;
    chk("wrap_cnt", retired_count, 0);
    chk("wrap_err", err_spurious_resp, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
